sha256_digest_reader: RTL and testbench
=======================================

SHA256_DIGEST_READER -- requirements
Module: sha256_digest_reader

Interface
REQ-001 SHALL have parameter: WORDS, 8, number of 32-bit digest words read per operation (legal range 1..8).
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a read-and-compare; sampled only in IDLE.
- digest_addr  in  16  word address of digest word 0 (most significant word).
- target  in  32*WORDS  unsigned threshold; bits [32*WORDS-1 -: 32] correspond to word 0.
- mem_clk  out  1  equals clk.
- mem_we  out  1  constant 0.
- mem_addr  out  16  registered read address.
- mem_read_data  in  32  synchronous memory read data.
- done  out  1  high in IDLE, low while busy.
- result_valid  out  1  high from completion until the next accepted start.
- digest  out  32*WORDS  captured words; word 0 in the MS bits.
- below_target  out  1  digest < target (unsigned).
- equal_target  out  1  digest == target.

Function
REQ-004 SHALL use memory timing: an address registered on edge N is sampled from mem_read_data on edge N+2.
REQ-005 SHALL implement states IDLE, FILL and READ.
REQ-006 IDLE with start=1 on edge E0 SHALL:
- latch digest_addr and target;
- set mem_addr to digest_addr;
- clear result_valid, below_target, equal_target and the compare flags;
- drive done=0;
- go to FILL.
REQ-007 FILL on edge E1 SHALL set mem_addr to digest_addr+1, set word counter to 0, and go to READ.
REQ-008 READ on edge E(2+i) SHALL capture mem_read_data as word i for i = 0..WORDS-1.
REQ-009 READ SHALL issue mem_addr = digest_addr+i+2 while i+2 < WORDS, otherwise hold mem_addr.
REQ-010 Address arithmetic SHALL be modulo 2^16 (0xFFFF+1 wraps to 0x0000).
REQ-011 Comparison SHALL be sequential, MSW first, using flags decided and lt.
REQ-012 On capture of word i with decided=0, the block SHALL compare against target word i:
- word < target word: set decided=1, lt=1;
- word > target word: set decided=1, lt=0;
- equal: leave flags unchanged.
REQ-013 Once decided=1, the flags SHALL hold for the rest of the operation.
REQ-014 On capture of the last word (edge E(WORDS+1)), the block SHALL:
- register below_target = final lt;
- register equal_target = NOT final decided;
- set result_valid=1 and done=1;
- return to IDLE.
REQ-015 Latency SHALL be WORDS+1 clocks from the start edge to done/result_valid high; 9 clocks for WORDS=8.
REQ-016 below_target and equal_target SHALL never both be 1.
REQ-017 start SHALL be ignored outside IDLE; changes to digest_addr or target after E0 SHALL not affect the operation.
REQ-018 start held high continuously SHALL begin a new operation on the first IDLE cycle after completion, which clears result_valid.
REQ-019 digest, below_target and equal_target SHALL hold their values in IDLE until the next accepted start.
REQ-020 digest words not yet captured in the current operation SHALL hold their previous values.
REQ-021 mem_we SHALL be 0 in every cycle, including reset.

Reset
REQ-022 When reset_n=0 at a rising edge, the block SHALL set:
- state = IDLE;
- done = 1;
- result_valid = 0;
- below_target = 0;
- equal_target = 0;
- mem_addr = 0x0000;
- digest = 0;
- word counter = 0;
- compare flags = 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no result_valid pulse; the first start after release SHALL behave per REQ-006.
REQ-024 Between the reset edge and its release, outputs SHALL not toggle.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Basic read: memory 0x0100..0x0107 = 0x00000001..0x00000008, target all 0xFFFFFFFF, start with digest_addr=0x0100 -> mem_addr sequence 0x0100..0x0107 on consecutive edges; done and result_valid high 9 clocks after start; digest=0x00000001_..._00000008; below_target=1, equal_target=0.
- Equal: target equal to the stored digest -> equal_target=1, below_target=0.
- Late decision: digest identical to target except word 7 = target word 7 + 1 -> below_target=0, equal_target=0; word 0 = target word 0 - 1 with word 7 larger -> below_target=1.
- Wrap: digest_addr=0xFFFC -> mem_addr sequence 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000..0x0003, and correct capture.
- Abort: reset_n=0 on the 5th clock after start -> result_valid stays 0 and done=1; a subsequent start completes normally with fresh results.
- Busy start and back-to-back: start pulsed during READ with a different digest_addr -> ignored; start held high -> second operation starts the cycle after done, result_valid drops for 9 clocks, mem_we 0 throughout.

Source files
------------

// File: rtl/sha256_digest_reader.sv
// Reads a WORDS x 32-bit digest from a synchronous memory, MSW first,
// and compares it, as one unsigned number, against a latched target.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start             begin an operation (sampled only in IDLE)
//   digest_addr       word address of digest word 0 (MSW)
//   target            unsigned threshold, word 0 in the MS bits
//   mem_clk, mem_we   memory clock (= clk), write enable (always 0)
//   mem_addr          registered read address
//   mem_read_data     read data, valid two edges after its address
//   done              high in IDLE, low while busy
//   result_valid      high from completion until the next start
//   digest            captured words, word 0 in the MS bits
//   below_target      digest < target
//   equal_target      digest == target

module sha256_digest_reader #(
    parameter int WORDS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           digest_addr,
    input  logic [32*WORDS-1:0]   target,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [15:0]           mem_addr,
    input  logic [31:0]           mem_read_data,
    output logic                  done,
    output logic                  result_valid,
    output logic [32*WORDS-1:0]   digest,
    output logic                  below_target,
    output logic                  equal_target
);

    localparam int DW = 32 * WORDS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READ
    } state_t;

    state_t        state;
    logic [15:0]   base;
    logic [DW-1:0] tgt;
    logic [3:0]    cnt;
    logic          decided;
    logic          lt;

    logic [31:0]   idx;
    logic [31:0]   tgt_word;
    logic          nxt_decided;
    logic          nxt_lt;
    logic          last;
    logic          more;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    // Compare the word arriving this cycle against its target word.
    // Only the first unequal word (MSW first) decides the outcome.
    always_comb begin
        idx      = 32'(cnt);
        tgt_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == 32'(i)) begin
                tgt_word = tgt[DW-1-32*i -: 32];
            end
        end
        nxt_decided = decided;
        nxt_lt      = lt;
        if (!decided) begin
            if (mem_read_data < tgt_word) begin
                nxt_decided = 1'b1;
                nxt_lt      = 1'b1;
            end else if (mem_read_data > tgt_word) begin
                nxt_decided = 1'b1;
                nxt_lt      = 1'b0;
            end
        end
        // Two reads are already in flight, so the next address
        // to issue is base + idx + 2.
        more = (idx + 32'd2) < 32'(WORDS);
        last = (idx == 32'(WORDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            done         <= 1'b1;
            result_valid <= 1'b0;
            below_target <= 1'b0;
            equal_target <= 1'b0;
            mem_addr     <= 16'h0000;
            digest       <= '0;
            cnt          <= 4'd0;
            decided      <= 1'b0;
            lt           <= 1'b0;
            base         <= 16'h0000;
            tgt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base         <= digest_addr;
                        tgt          <= target;
                        mem_addr     <= digest_addr;
                        result_valid <= 1'b0;
                        below_target <= 1'b0;
                        equal_target <= 1'b0;
                        decided      <= 1'b0;
                        lt           <= 1'b0;
                        done         <= 1'b0;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    mem_addr <= base + 16'd1;
                    cnt      <= 4'd0;
                    state    <= READ;
                end
                READ: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx == 32'(i)) begin
                            digest[DW-1-32*i -: 32] <= mem_read_data;
                        end
                    end
                    decided <= nxt_decided;
                    lt      <= nxt_lt;
                    if (more) begin
                        mem_addr <= base + idx[15:0] + 16'd2;
                    end
                    if (last) begin
                        below_target <= nxt_lt;
                        equal_target <= ~nxt_decided;
                        result_valid <= 1'b1;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Self-checking bench for sha256_digest_reader: directed scenarios
// plus randomized operations against a whole-number reference model.

module tb_sha256_digest_reader;

    localparam int W  = 8;
    localparam int DW = 32 * W;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [15:0]   digest_addr;
    logic [DW-1:0] target;
    logic          mem_clk;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_read_data;
    logic          done;
    logic          result_valid;
    logic [DW-1:0] digest;
    logic          below_target;
    logic          equal_target;

    logic [31:0]   mem [0:65535];
    logic [DW-1:0] last_digest;

    int n_chk;
    int n_fail;

    sha256_digest_reader #(.WORDS(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .digest_addr   (digest_addr),
        .target        (target),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .done          (done),
        .result_valid  (result_valid),
        .digest        (digest),
        .below_target  (below_target),
        .equal_target  (equal_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: one registered read stage.
    always @(posedge mem_clk) mem_read_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [15:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < W; i++)
            d[DW-1-32*i -: 32] = mem[16'(a + i)];
        return d;
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] a,
                                             input int k);
        int o;
        o = (k < W - 1) ? k : W - 1;
        return 16'(a + o);
    endfunction

    // Caller is at a negedge; E0 is the next posedge.
    task automatic run_op(input logic [15:0] a, input logic [DW-1:0] t,
                          input bit hold, input bit poke);
        logic [DW-1:0] exp_d;
        logic          exp_lt;
        logic          exp_eq;
        exp_d  = model_read(a);
        exp_lt = (exp_d < t);
        exp_eq = (exp_d == t);
        digest_addr = a;
        target      = t;
        start       = 1'b1;
        for (int k = 0; k <= W + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0 && !hold) start = 1'b0;
            check("mem_addr", DW'(mem_addr), DW'(exp_addr(a, k)));
            check("mem_we", DW'(mem_we), '0);
            if (k <= W) begin
                check("busy_done", DW'(done), '0);
                check("busy_rv", DW'(result_valid), '0);
            end
            if (k == 2)
                check("partial_digest", digest,
                      {exp_d[DW-1 -: 32], last_digest[DW-33:0]});
            if (k == 3 && poke) begin
                start       = 1'b1;
                digest_addr = a ^ 16'h5a5a;
                target      = ~t;
            end
            if (k == 4 && poke) start = 1'b0;
        end
        check("done", DW'(done), DW'(1));
        check("result_valid", DW'(result_valid), DW'(1));
        check("digest", digest, exp_d);
        check("below", DW'(below_target), DW'(exp_lt));
        check("equal", DW'(equal_target), DW'(exp_eq));
        check("excl", DW'(below_target & equal_target), '0);
        last_digest = exp_d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_done"}, DW'(done), DW'(1));
        check({tag, "_rv"}, DW'(result_valid), '0);
        check({tag, "_addr"}, DW'(mem_addr), '0);
        check({tag, "_digest"}, digest, '0);
        check({tag, "_below"}, DW'(below_target), '0);
        check({tag, "_equal"}, DW'(equal_target), '0);
        check({tag, "_we"}, DW'(mem_we), '0);
    endtask

    initial begin
        logic [DW-1:0] t;
        logic [DW-1:0] d;
        logic [15:0]   a;
        int            mode;
        int            j;
        n_chk       = 0;
        n_fail      = 0;
        last_digest = '0;
        reset_n     = 1'b0;
        start       = 1'b0;
        digest_addr = 16'h0000;
        target      = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < W; i++) mem[16'h0100 + i] = 32'(i + 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("idle");

        // Basic read
        run_op(16'h0100, {W{32'hFFFF_FFFF}}, 0, 0);
        check("basic_digest", digest,
              {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
        check("basic_below", DW'(below_target), DW'(1));

        // Equal
        run_op(16'h0100, model_read(16'h0100), 0, 0);
        check("eq_equal", DW'(equal_target), DW'(1));

        // Late decision: word 7 one above target
        t = model_read(16'h0100);
        t[31:0] = t[31:0] - 32'd1;
        run_op(16'h0100, t, 0, 0);
        check("late_below", DW'(below_target), '0);
        check("late_equal", DW'(equal_target), '0);

        // Word 0 below target wins over larger word 7
        t[DW-1 -: 32] = t[DW-1 -: 32] + 32'd1;
        run_op(16'h0100, t, 0, 0);
        check("msw_below", DW'(below_target), DW'(1));

        // Address wrap
        for (int i = 0; i < W; i++)
            mem[16'(16'hFFFC + i)] = 32'hA000_0000 + 32'(i);
        run_op(16'hFFFC, '0, 0, 0);
        check("wrap_digest", digest[31:0], DW'(32'hA000_0007));

        // Abort by reset on the 5th clock after start
        digest_addr = 16'h0100;
        target      = '1;
        start       = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("abort_busy", DW'(done), '0);
        end
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_state("abort");
        end
        last_digest = '0;
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_rv", DW'(result_valid), '0);
        run_op(16'hFFFC, {W{32'h8000_0000}}, 0, 0);

        // Busy start is ignored
        run_op(16'h0100, {W{32'h0000_0003}}, 0, 1);

        // Back-to-back with start held high
        run_op(16'h0100, '1, 1, 0);
        run_op(16'hFFFC, '0, 0, 0);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            for (int i = 0; i < W; i++) mem[16'(a + i)] = $urandom;
            d    = model_read(a);
            mode = $urandom_range(0, 3);
            j    = $urandom_range(0, W - 1);
            case (mode)
                0: for (int i = 0; i < W; i++) t[32*i +: 32] = $urandom;
                1: t = d;
                2: begin
                    t = d;
                    t[DW-1-32*j -: 32] = t[DW-1-32*j -: 32] + 32'd1;
                end
                default: begin
                    t = d;
                    t[DW-1-32*j -: 32] = t[DW-1-32*j -: 32] - 32'd1;
                end
            endcase
            run_op(a, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            start = 1'b0;
        end

        repeat (2) @(negedge clk);
        check("final_idle", DW'(done), DW'(1));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
